led_pattern_checker: RTL and testbench

LED_PATTERN_CHECKER -- requirements
Module: led_pattern_checker

---
 rtl/led_pattern_checker.sv | 174 +++++++++++++++++
 tb/tb_led_pattern_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_checker.sv
// led_pattern_checker: tracks a one-hot LED chaser (rotate-left sequence),
// declares lock after LOCK_CNT correct steps and flags sequence errors or
// stalls while locked.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset_n    - asynchronous active-low reset
//   leds_in    - 4-bit LED bus under observation
//   sample_en  - qualifies leds_in as a sample
//   locked     - high while in LOCKED
//   position   - index of the set bit of the last valid sample
//   err_pulse  - one-cycle pulse on a sequence error or stall while locked
//   stall      - one-cycle pulse, with err_pulse, on dwell timeout only
//   err_count  - saturating count of err_pulse events
module led_pattern_checker #(
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned MAX_DWELL = 16,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       leds_in,
    input  logic             sample_en,
    output logic             locked,
    output logic [1:0]       position,
    output logic             err_pulse,
    output logic             stall,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned GOOD_W = 4;
    localparam int unsigned DWELL_W = 8;
    localparam logic [GOOD_W-1:0]  LOCK_CNT_C  = GOOD_W'(LOCK_CNT);
    localparam logic [DWELL_W-1:0] MAX_DWELL_C = DWELL_W'(MAX_DWELL);
    localparam logic [ERR_W-1:0]   ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                locked_d;
    logic [1:0]          position_d;
    logic                err_pulse_d;
    logic                stall_d;
    logic [ERR_W-1:0]    err_count_d;

    logic                valid_c;
    logic [1:0]          enc_c;
    logic [3:0]          succ_c;

    // One-hot decode of the current sample
    always_comb begin
        valid_c = 1'b1;
        enc_c   = 2'd0;
        case (leds_in)
            4'b0001: enc_c = 2'd0;
            4'b0010: enc_c = 2'd1;
            4'b0100: enc_c = 2'd2;
            4'b1000: enc_c = 2'd3;
            default: valid_c = 1'b0;
        endcase
    end

    // Expected next pattern: rotate-left of the last accepted one
    assign succ_c = {prev_q[2:0], prev_q[3]};

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEARCH;
            prev_q    <= 4'b0000;
            good_q    <= '0;
            dwell_q   <= '0;
            locked    <= 1'b0;
            position  <= 2'd0;
            err_pulse <= 1'b0;
            stall     <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            good_q    <= good_d;
            dwell_q   <= dwell_d;
            locked    <= locked_d;
            position  <= position_d;
            err_pulse <= err_pulse_d;
            stall     <= stall_d;
            err_count <= err_count_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_d      = good_q;
        dwell_d     = dwell_q;
        position_d  = position;
        err_pulse_d = 1'b0;
        stall_d     = 1'b0;
        err_count_d = err_count;

        if (sample_en) begin
            if (valid_c) begin
                position_d = enc_c;
            end
            case (state_q)
                SEARCH: begin
                    if (valid_c) begin
                        state_d = TRACK;
                        prev_d  = leds_in;
                        good_d  = '0;
                        dwell_d = '0;
                    end
                end
                TRACK: begin
                    if (leds_in == prev_q) begin
                        // Dwell saturates silently before lock
                        if (dwell_q < MAX_DWELL_C) begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end else if (leds_in == succ_c) begin
                        good_d  = good_q + GOOD_W'(1);
                        dwell_d = '0;
                        prev_d  = leds_in;
                        if (good_q + GOOD_W'(1) == LOCK_CNT_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = SEARCH;
                        good_d  = '0;
                        dwell_d = '0;
                    end
                end
                LOCKED: begin
                    if (leds_in == prev_q) begin
                        if (dwell_q + DWELL_W'(1) == MAX_DWELL_C) begin
                            err_pulse_d = 1'b1;
                            stall_d     = 1'b1;
                            state_d     = SEARCH;
                            good_d      = '0;
                            dwell_d     = '0;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end else if (leds_in == succ_c) begin
                        prev_d  = leds_in;
                        dwell_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        state_d     = SEARCH;
                        good_d      = '0;
                        dwell_d     = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
            if (err_pulse_d && (err_count != ERR_MAX)) begin
                err_count_d = err_count + ERR_W'(1);
            end
        end

        locked_d = (state_d == LOCKED);
    end

endmodule

// File: tb/tb_led_pattern_checker.sv
// Directed bench for led_pattern_checker (LOCK_CNT=3, MAX_DWELL=4, ERR_W=2).
module tb_led_pattern_checker;

    logic       clk;
    logic       reset_n;
    logic [3:0] leds_in;
    logic       sample_en;
    logic       locked;
    logic [1:0] position;
    logic       err_pulse;
    logic       stall;
    logic [1:0] err_count;

    int checks;
    int errors;

    led_pattern_checker #(
        .LOCK_CNT (3),
        .MAX_DWELL(4),
        .ERR_W    (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .leds_in  (leds_in),
        .sample_en(sample_en),
        .locked   (locked),
        .position (position),
        .err_pulse(err_pulse),
        .stall    (stall),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, then settle just after the rising edge
    task automatic step(input logic [3:0] leds, input logic en);
        @(negedge clk);
        leds_in   = leds;
        sample_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic l, input logic [1:0] p,
                           input logic e, input logic s, input logic [1:0] c);
        check({tag, ".locked"},    8'(locked),    8'(l));
        check({tag, ".position"},  8'(position),  8'(p));
        check({tag, ".err_pulse"}, 8'(err_pulse), 8'(e));
        check({tag, ".stall"},     8'(stall),     8'(s));
        check({tag, ".err_count"}, 8'(err_count), 8'(c));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        leds_in   = 4'b0000;
        sample_en = 1'b0;
        #12;
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic lock: 0001,0010,0100,1000
        step(4'b0001, 1'b1); chk_out("lk1", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        step(4'b0010, 1'b1); chk_out("lk2", 1'b0, 2'd1, 1'b0, 1'b0, 2'd0);
        step(4'b0100, 1'b1); chk_out("lk3", 1'b0, 2'd2, 1'b0, 1'b0, 2'd0);
        step(4'b1000, 1'b1); chk_out("lk4", 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);

        // Wrap 1000 -> 0001 keeps lock
        step(4'b0001, 1'b1); chk_out("wrap", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);

        // Multi-bit sample while locked at 0010
        step(4'b0010, 1'b1); chk_out("pre_bad", 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        step(4'b0110, 1'b1); chk_out("bad", 1'b0, 2'd1, 1'b1, 1'b0, 2'd1);
        step(4'b0100, 1'b0); chk_out("bad_next", 1'b0, 2'd1, 1'b0, 1'b0, 2'd1);

        // Relock ending on 0100, then stall after four repeats
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1); chk_out("relock1", 1'b1, 2'd1, 1'b0, 1'b0, 2'd1);
        step(4'b0100, 1'b1); chk_out("on0100", 1'b1, 2'd2, 1'b0, 1'b0, 2'd1);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1); chk_out("dwell3", 1'b1, 2'd2, 1'b0, 1'b0, 2'd1);
        step(4'b0100, 1'b1); chk_out("stall", 1'b0, 2'd2, 1'b1, 1'b1, 2'd2);
        step(4'b0100, 1'b0); chk_out("stall_next", 1'b0, 2'd2, 1'b0, 1'b0, 2'd2);

        // Relock, then sample_en toggling with garbage in idle cycles
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1); chk_out("relock2", 1'b1, 2'd3, 1'b0, 1'b0, 2'd2);
        step(4'b0001, 1'b1);
        step(4'b0110, 1'b0); chk_out("idle1", 1'b1, 2'd0, 1'b0, 1'b0, 2'd2);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b0); chk_out("idle2", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2);
        // Repeats separated by idle cycles: only enabled ones advance dwell
        step(4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0); chk_out("dwell_hold", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2);
        step(4'b0100, 1'b1); chk_out("dwell_succ", 1'b1, 2'd2, 1'b0, 1'b0, 2'd2);

        // Saturate err_count: errors 3, 4, 5
        step(4'b0000, 1'b1); chk_out("err3", 1'b0, 2'd2, 1'b1, 1'b0, 2'd3);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1); check("relock3.locked", 8'(locked), 8'd1);
        step(4'b1111, 1'b1); chk_out("err4", 1'b0, 2'd2, 1'b1, 1'b0, 2'd3);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1); check("relock4.locked", 8'(locked), 8'd1);
        step(4'b0100, 1'b1); chk_out("err5", 1'b0, 2'd2, 1'b1, 1'b0, 2'd3);

        // Asynchronous reset mid-lock, checked before any further edge
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1); check("relock5.locked", 8'(locked), 8'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // History discarded: successor of old prev does not lock
        step(4'b0001, 1'b1); chk_out("post_rst", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        // Wrong sample in TRACK returns to SEARCH silently
        step(4'b1000, 1'b1); chk_out("trk_wrong", 1'b0, 2'd3, 1'b0, 1'b0, 2'd0);

        // Long dwell in TRACK saturates without error, then lock still possible
        step(4'b0100, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0100, 1'b1);
        chk_out("trk_dwell", 1'b0, 2'd2, 1'b0, 1'b0, 2'd0);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1); chk_out("relock6", 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
